// File: rtl/net_pkg.sv
// Shared network constants, ARP parser state encoding and result payload.
package net_pkg;

    localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
    localparam logic [15:0] IP_TYPE       = 16'h0800;
    localparam logic [7:0]  ARP_HLEN      = 8'd6;
    localparam logic [7:0]  ARP_PLEN      = 8'd4;
    localparam logic [15:0] ARP_OP_REQ    = 16'd1;
    localparam logic [15:0] ARP_OP_REPLY  = 16'd2;

    localparam int unsigned ARP_IDX_W = 5;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        RECV,
        HOLD
    } arp_rx_state_t;

    typedef struct packed {
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
    } arp_result_t;

    // True when a byte at the given payload index violates a fixed field or the target IP.
    function automatic logic arp_field_bad(input logic [ARP_IDX_W-1:0] idx,
                                           input logic [7:0]           d,
                                           input logic [31:0]          local_ip);
        logic bad;
        bad = 1'b0;
        case (idx)
            5'd0:    bad = (d != ARP_HTYPE_ETH[15:8]);
            5'd1:    bad = (d != ARP_HTYPE_ETH[7:0]);
            5'd2:    bad = (d != IP_TYPE[15:8]);
            5'd3:    bad = (d != IP_TYPE[7:0]);
            5'd4:    bad = (d != ARP_HLEN);
            5'd5:    bad = (d != ARP_PLEN);
            5'd6:    bad = (d != ARP_OP_REQ[15:8]);
            5'd7:    bad = (d != ARP_OP_REQ[7:0]) && (d != ARP_OP_REPLY[7:0]);
            5'd24:   bad = (d != local_ip[31:24]);
            5'd25:   bad = (d != local_ip[23:16]);
            5'd26:   bad = (d != local_ip[15:8]);
            5'd27:   bad = (d != local_ip[7:0]);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16
    import net_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en && (q != {CNT_W{1'b1}})) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/arp_rx.sv
// ARP receive parser: validates the 28-byte payload, extracts sender fields and
// holds one result on a valid/ready handshake until the consumer takes it.
module arp_rx
    import net_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP   = 32'hC0A8_006E,
    parameter int unsigned ARP_LENGTH = 28
) (
    input  logic        logic_clk,
    input  logic        logic_rst_n,
    input  logic [7:0]  arp_rdata_in,
    input  logic        arp_rvalid_in,
    output logic        arp_rready_out,
    input  logic        arp_rlast_in,
    output logic        arp_valid_out,
    input  logic        arp_ready_in,
    output logic [15:0] arp_oper_out,
    output logic [47:0] arp_sha_out,
    output logic [31:0] arp_spa_out,
    output logic [15:0] arp_ok_cnt_out,
    output logic [15:0] arp_err_cnt_out
);

    localparam logic [ARP_IDX_W-1:0] LAST_IDX = ARP_IDX_W'(ARP_LENGTH - 1);
    localparam logic [ARP_IDX_W-1:0] IDX_MAX  = {ARP_IDX_W{1'b1}};

    arp_rx_state_t        state, state_next;
    logic [ARP_IDX_W-1:0] cnt, cnt_next, cnt_inc;
    logic                 err, err_next, err_now;
    arp_result_t          cap, cap_next;
    arp_result_t          res, res_next;
    logic                 valid_next, rready_next;
    logic                 ok_inc, err_inc;
    logic                 beat;

    assign beat    = arp_rvalid_in & arp_rready_out;
    assign cnt_inc = (cnt == IDX_MAX) ? cnt : cnt + ARP_IDX_W'(1);

    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            state          <= SYNC;
            cnt            <= '0;
            err            <= 1'b0;
            cap            <= '0;
            res            <= '0;
            arp_valid_out  <= 1'b0;
            arp_rready_out <= 1'b1;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            err            <= err_next;
            cap            <= cap_next;
            res            <= res_next;
            arp_valid_out  <= valid_next;
            arp_rready_out <= rready_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        err_next    = err;
        cap_next    = cap;
        res_next    = res;
        valid_next  = arp_valid_out;
        rready_next = arp_rready_out;
        ok_inc      = 1'b0;
        err_inc     = 1'b0;
        err_now     = err | arp_field_bad(cnt, arp_rdata_in, LOCAL_IP);

        // Field capture by byte index; SHA/SPA shift in big-endian.
        if (beat && ((state == IDLE) || (state == RECV))) begin
            if (cnt == 5'd6) begin
                cap_next.oper[15:8] = arp_rdata_in;
            end else if (cnt == 5'd7) begin
                cap_next.oper[7:0] = arp_rdata_in;
            end else if ((cnt >= 5'd8) && (cnt <= 5'd13)) begin
                cap_next.sha = {cap.sha[39:0], arp_rdata_in};
            end else if ((cnt >= 5'd14) && (cnt <= 5'd17)) begin
                cap_next.spa = {cap.spa[23:0], arp_rdata_in};
            end
        end

        case (state)
            SYNC: begin
                if (!arp_rvalid_in || (beat && arp_rlast_in)) begin
                    state_next = IDLE;
                end
            end
            IDLE, RECV: begin
                if (beat) begin
                    if (arp_rlast_in) begin
                        cnt_next = '0;
                        err_next = 1'b0;
                        if ((cnt < LAST_IDX) || err_now) begin
                            err_inc    = 1'b1;
                            state_next = IDLE;
                        end else begin
                            res_next    = cap_next;
                            valid_next  = 1'b1;
                            rready_next = 1'b0;
                            state_next  = HOLD;
                        end
                    end else begin
                        cnt_next   = cnt_inc;
                        err_next   = err_now;
                        state_next = RECV;
                    end
                end
            end
            HOLD: begin
                if (arp_valid_out && arp_ready_in) begin
                    ok_inc      = 1'b1;
                    valid_next  = 1'b0;
                    rready_next = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = SYNC;
        endcase
    end

    assign arp_oper_out = res.oper;
    assign arp_sha_out  = res.sha;
    assign arp_spa_out  = res.spa;

    sat_cnt16 u_ok_cnt (
        .clk   (logic_clk),
        .rst_n (logic_rst_n),
        .en    (ok_inc),
        .q     (arp_ok_cnt_out)
    );

    sat_cnt16 u_err_cnt (
        .clk   (logic_clk),
        .rst_n (logic_rst_n),
        .en    (err_inc),
        .q     (arp_err_cnt_out)
    );

endmodule

// File: tb/tb_arp_rx.sv
// Directed bench for arp_rx: frame table plus hand-written handshake, reset and saturation sequences.
module tb_arp_rx;

    localparam logic [31:0] MY_IP = 32'hC0A8_006E;

    logic        logic_clk = 1'b0;
    logic        logic_rst_n = 1'b0;
    logic [7:0]  arp_rdata_in = 8'h00;
    logic        arp_rvalid_in = 1'b0;
    logic        arp_rready_out;
    logic        arp_rlast_in = 1'b0;
    logic        arp_valid_out;
    logic        arp_ready_in = 1'b0;
    logic [15:0] arp_oper_out;
    logic [47:0] arp_sha_out;
    logic [31:0] arp_spa_out;
    logic [15:0] arp_ok_cnt_out;
    logic [15:0] arp_err_cnt_out;

    always #5 logic_clk = ~logic_clk;

    arp_rx dut (
        .logic_clk       (logic_clk),
        .logic_rst_n     (logic_rst_n),
        .arp_rdata_in    (arp_rdata_in),
        .arp_rvalid_in   (arp_rvalid_in),
        .arp_rready_out  (arp_rready_out),
        .arp_rlast_in    (arp_rlast_in),
        .arp_valid_out   (arp_valid_out),
        .arp_ready_in    (arp_ready_in),
        .arp_oper_out    (arp_oper_out),
        .arp_sha_out     (arp_sha_out),
        .arp_spa_out     (arp_spa_out),
        .arp_ok_cnt_out  (arp_ok_cnt_out),
        .arp_err_cnt_out (arp_err_cnt_out)
    );

    typedef struct {
        logic [15:0] htype;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [31:0] tpa;
        int          len;
        bit          ok;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] frm[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_ok = 0;
    int         exp_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Payload bytes of one frame, truncated or padded (0xA5) to v.len.
    task automatic build(input vec_t v);
        logic [7:0] b[$];
        b = {v.htype[15:8], v.htype[7:0], 8'h08, 8'h00, 8'h06, 8'h04,
             v.oper[15:8], v.oper[7:0],
             v.sha[47:40], v.sha[39:32], v.sha[31:24], v.sha[23:16], v.sha[15:8], v.sha[7:0],
             v.spa[31:24], v.spa[23:16], v.spa[15:8], v.spa[7:0],
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             v.tpa[31:24], v.tpa[23:16], v.tpa[15:8], v.tpa[7:0]};
        frm.delete();
        for (int i = 0; i < v.len; i++) frm.push_back((i < 28) ? b[i] : 8'hA5);
    endtask

    // Present one byte and return #1 after the edge on which it was accepted.
    task automatic send_byte(input logic [7:0] d, input logic last);
        logic rp;
        int   n;
        n = 0;
        arp_rdata_in  = d;
        arp_rlast_in  = last;
        arp_rvalid_in = 1'b1;
        forever begin
            rp = arp_rready_out;
            @(posedge logic_clk);
            #1;
            if (rp) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL byte_accept_timeout actual=%0d required=%0d", n, 200);
                break;
            end
        end
    endtask

    task automatic send_range(input int from, input int to_excl);
        for (int i = from; i < to_excl; i++) send_byte(frm[i], (i == frm.size() - 1));
    endtask

    task automatic end_frame();
        arp_rvalid_in = 1'b0;
        arp_rlast_in  = 1'b0;
    endtask

    task automatic check_result(input string nm, input vec_t v);
        chk({nm, "_valid"}, 64'(arp_valid_out), 64'd1);
        chk({nm, "_rready_hold"}, 64'(arp_rready_out), 64'd0);
        chk({nm, "_oper"}, 64'(arp_oper_out), 64'(v.oper));
        chk({nm, "_sha"}, 64'(arp_sha_out), 64'(v.sha));
        chk({nm, "_spa"}, 64'(arp_spa_out), 64'(v.spa));
    endtask

    task automatic handshake(input string nm);
        arp_ready_in = 1'b1;
        @(posedge logic_clk);
        #1;
        arp_ready_in = 1'b0;
        exp_ok++;
        chk({nm, "_valid_drop"}, 64'(arp_valid_out), 64'd0);
        chk({nm, "_rready_back"}, 64'(arp_rready_out), 64'd1);
        chk({nm, "_ok_cnt"}, 64'(arp_ok_cnt_out), 64'(exp_ok));
    endtask

    initial begin
        vecs[0] = '{16'h0001, 16'd1, 48'h001122334455, 32'hC0A80001, MY_IP,         46, 1'b1};
        vecs[1] = '{16'h0001, 16'd1, 48'h0A0B0C0D0E0F, 32'hC0A80002, 32'hC0A80099, 28, 1'b0};
        vecs[2] = '{16'h0001, 16'd2, 48'hDEADBEEF0102, 32'h0A000001, MY_IP,         28, 1'b1};
        vecs[3] = '{16'h0001, 16'd1, 48'h001122334455, 32'hC0A80001, MY_IP,         21, 1'b0};
        vecs[4] = '{16'h0006, 16'd1, 48'h001122334455, 32'hC0A80001, MY_IP,         28, 1'b0};
        vecs[5] = '{16'h0001, 16'd3, 48'h001122334455, 32'hC0A80001, MY_IP,         46, 1'b0};
        vecs[6] = '{16'h0001, 16'd1, 48'hFEDCBA987654, 32'hC0A8FFFE, MY_IP,         30, 1'b1};

        // Reset values
        #12;
        chk("rst_rready", 64'(arp_rready_out), 64'd1);
        chk("rst_valid", 64'(arp_valid_out), 64'd0);
        chk("rst_oper", 64'(arp_oper_out), 64'd0);
        chk("rst_sha", 64'(arp_sha_out), 64'd0);
        chk("rst_spa", 64'(arp_spa_out), 64'd0);
        chk("rst_ok", 64'(arp_ok_cnt_out), 64'd0);
        chk("rst_err", 64'(arp_err_cnt_out), 64'd0);
        logic_rst_n = 1'b1;
        repeat (3) @(posedge logic_clk);
        #1;

        // Table: each frame either produces a result one cycle after rlast or bumps err_cnt
        for (int i = 0; i < 7; i++) begin
            build(vecs[i]);
            send_range(0, frm.size());
            end_frame();
            if (vecs[i].ok) begin
                check_result($sformatf("v%0d", i), vecs[i]);
                handshake($sformatf("v%0d", i));
            end else begin
                exp_err++;
                chk($sformatf("v%0d_no_valid", i), 64'(arp_valid_out), 64'd0);
                chk($sformatf("v%0d_err_cnt", i), 64'(arp_err_cnt_out), 64'(exp_err));
            end
            @(posedge logic_clk);
            #1;
        end

        // Back-pressure: result held 10 cycles while next frame waits
        build(vecs[0]);
        send_range(0, frm.size());
        end_frame();
        check_result("bp_first", vecs[0]);
        build(vecs[2]);
        arp_rdata_in  = frm[0];
        arp_rvalid_in = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge logic_clk);
            #1;
            chk($sformatf("bp_rready_c%0d", c), 64'(arp_rready_out), 64'd0);
            chk($sformatf("bp_sha_c%0d", c), 64'(arp_sha_out), 64'(vecs[0].sha));
        end
        chk("bp_oper_stable", 64'(arp_oper_out), 64'(vecs[0].oper));
        handshake("bp_first");
        send_range(0, frm.size());
        end_frame();
        check_result("bp_second", vecs[2]);
        handshake("bp_second");
        @(posedge logic_clk);
        #1;

        // Reset asserted mid-frame and released with rvalid high: SYNC drains the remainder
        build(vecs[0]);
        send_range(0, 10);
        logic_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(arp_valid_out), 64'd0);
        chk("mid_rst_ok", 64'(arp_ok_cnt_out), 64'd0);
        chk("mid_rst_err", 64'(arp_err_cnt_out), 64'd0);
        @(posedge logic_clk);
        #2;
        logic_rst_n = 1'b1;
        exp_ok = 0;
        exp_err = 0;
        send_range(10, frm.size());
        end_frame();
        chk("sync_no_valid", 64'(arp_valid_out), 64'd0);
        @(posedge logic_clk);
        #1;
        chk("sync_err", 64'(arp_err_cnt_out), 64'd0);
        chk("sync_ok", 64'(arp_ok_cnt_out), 64'd0);
        build(vecs[6]);
        send_range(0, frm.size());
        end_frame();
        check_result("post_sync", vecs[6]);
        handshake("post_sync");

        // Saturation: back-to-back one-byte frames each count as an error
        arp_rdata_in  = 8'h00;
        arp_rlast_in  = 1'b1;
        arp_rvalid_in = 1'b1;
        repeat (65534) @(posedge logic_clk);
        #1;
        chk("sat_fffe", 64'(arp_err_cnt_out), 64'hFFFE);
        repeat (5) @(posedge logic_clk);
        #1;
        chk("sat_ffff", 64'(arp_err_cnt_out), 64'hFFFF);
        end_frame();
        @(posedge logic_clk);
        #1;
        chk("sat_hold", 64'(arp_err_cnt_out), 64'hFFFF);
        chk("sat_ok_unchanged", 64'(arp_ok_cnt_out), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
